// File: rtl/frame_peak_finder.sv
// Streaming peak tracker: keeps the two largest distinct qualifying bins
// of each frame and presents them with a beat count once the frame closes.
module frame_peak_finder #(
    parameter int IDX_W = 10,
    parameter int VAL_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_index,
    input  logic [VAL_W-1:0] in_value,
    input  logic             in_last,
    input  logic [VAL_W-1:0] threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             peak_found,
    output logic [IDX_W-1:0] peak_index,
    output logic [VAL_W-1:0] peak_value,
    output logic             second_found,
    output logic [IDX_W-1:0] second_index,
    output logic [VAL_W-1:0] second_value,
    output logic [IDX_W:0]   bin_count
);

    typedef enum logic {
        ACCUM,
        REPORT
    } state_t;

    localparam logic [IDX_W:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             pk_vld_q, pk_vld_d;
    logic [IDX_W-1:0] pk_idx_q, pk_idx_d;
    logic [VAL_W-1:0] pk_val_q, pk_val_d;
    logic             sc_vld_q, sc_vld_d;
    logic [IDX_W-1:0] sc_idx_q, sc_idx_d;
    logic [VAL_W-1:0] sc_val_q, sc_val_d;
    logic [IDX_W:0]   cnt_q, cnt_d;

    logic accept;
    logic qual;
    logic beats_best;
    logic beats_sec;

    assign accept = in_valid && (state_q == ACCUM);
    assign qual   = in_value >= threshold;

    // A value equal to the best is a tie with it and is dropped entirely,
    // so the runner-up is always strictly below the peak.
    assign beats_best = qual && (!pk_vld_q || in_value > pk_val_q);
    assign beats_sec  = qual && pk_vld_q && (in_value < pk_val_q)
                     && (!sc_vld_q || in_value > sc_val_q);

    always_comb begin
        state_d  = state_q;
        pk_vld_d = pk_vld_q;
        pk_idx_d = pk_idx_q;
        pk_val_d = pk_val_q;
        sc_vld_d = sc_vld_q;
        sc_idx_d = sc_idx_q;
        sc_val_d = sc_val_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    unique case (1'b1)
                        beats_best: begin
                            sc_vld_d = pk_vld_q;
                            sc_idx_d = pk_idx_q;
                            sc_val_d = pk_val_q;
                            pk_vld_d = 1'b1;
                            pk_idx_d = in_index;
                            pk_val_d = in_value;
                        end
                        beats_sec: begin
                            sc_vld_d = 1'b1;
                            sc_idx_d = in_index;
                            sc_val_d = in_value;
                        end
                        default: ;
                    endcase
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d  = ACCUM;
                    pk_vld_d = 1'b0;
                    pk_idx_d = '0;
                    pk_val_d = '0;
                    sc_vld_d = 1'b0;
                    sc_idx_d = '0;
                    sc_val_d = '0;
                    cnt_d    = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            pk_vld_q <= 1'b0;
            pk_idx_q <= '0;
            pk_val_q <= '0;
            sc_vld_q <= 1'b0;
            sc_idx_q <= '0;
            sc_val_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pk_vld_q <= pk_vld_d;
            pk_idx_q <= pk_idx_d;
            pk_val_q <= pk_val_d;
            sc_vld_q <= sc_vld_d;
            sc_idx_q <= sc_idx_d;
            sc_val_q <= sc_val_d;
            cnt_q    <= cnt_d;
        end
    end

    // Trackers are zeroed whenever their valid bit is clear, so they can
    // drive the result ports directly.
    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == REPORT);
    assign peak_found   = pk_vld_q;
    assign peak_index   = pk_idx_q;
    assign peak_value   = pk_val_q;
    assign second_found = sc_vld_q;
    assign second_index = sc_idx_q;
    assign second_value = sc_val_q;
    assign bin_count    = cnt_q;

endmodule
